// File: rtl/mul_unit.sv
// Pipelined signed 32x32 multiply unit with a valid/grant write-back handshake.
// The whole pipe freezes while the head result waits for its grant.
module mul_unit #(
  parameter int unsigned STAGES = 4,
  parameter int unsigned CNT_W  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             iss_mul_oper,
  input  logic [31:0]      iss_ex_rega,
  input  logic [31:0]      iss_ex_regb,
  input  logic [4:0]       iss_ex_regdest,
  input  logic             iss_ex_writereg,
  input  logic             wb_grant,
  output logic             mul_wb_valid,
  output logic [31:0]      mul_wb_lo,
  output logic [31:0]      mul_wb_hi,
  output logic [4:0]       mul_wb_regdest,
  output logic             mul_wb_writereg,
  output logic             mul_busy,
  output logic [CNT_W-1:0] mul_inflight,
  output logic             mul_overrun
);

  localparam int unsigned HEAD = STAGES - 1;

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] wr_q;
  logic [4:0]        tag_q  [STAGES];
  logic [63:0]       prod_q [STAGES];
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic              overrun_q;

  logic              hold, accept, consume;
  logic [63:0]       prod_d;
  logic [4:0]        tag_d;
  logic              wr_d;

  assign hold    = vld_q[HEAD] & ~wb_grant;
  assign accept  = iss_mul_oper & ~hold;
  assign consume = vld_q[HEAD] & wb_grant;

  // Bubbles carry zeroed payload so the head never exposes stale or X data.
  always_comb begin
    prod_d = '0;
    tag_d  = '0;
    wr_d   = 1'b0;
    if (accept) begin
      prod_d = $signed(iss_ex_rega) * $signed(iss_ex_regb);
      tag_d  = iss_ex_regdest;
      wr_d   = iss_ex_writereg;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (accept && !consume)
      inflight_d = inflight_q + CNT_W'(1);
    else if (!accept && consume)
      inflight_d = inflight_q - CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q      <= '0;
      wr_q       <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        tag_q[i]  <= '0;
        prod_q[i] <= '0;
      end
      inflight_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      if (iss_mul_oper && hold)
        overrun_q <= 1'b1;
      inflight_q <= inflight_d;
      if (!hold) begin
        vld_q[0]  <= accept;
        wr_q[0]   <= wr_d;
        tag_q[0]  <= tag_d;
        prod_q[0] <= prod_d;
        for (int unsigned i = 1; i < STAGES; i++) begin
          vld_q[i]  <= vld_q[i-1];
          wr_q[i]   <= wr_q[i-1];
          tag_q[i]  <= tag_q[i-1];
          prod_q[i] <= prod_q[i-1];
        end
      end
    end
  end

  assign mul_wb_valid    = vld_q[HEAD];
  assign mul_wb_lo       = prod_q[HEAD][31:0];
  assign mul_wb_hi       = prod_q[HEAD][63:32];
  assign mul_wb_regdest  = tag_q[HEAD];
  assign mul_wb_writereg = wr_q[HEAD];
  assign mul_busy        = hold;
  assign mul_inflight    = inflight_q;
  assign mul_overrun     = overrun_q;

endmodule

// File: tb/tb_mul_unit.sv
// Directed testbench for mul_unit: latency, streaming, hold/grant, overrun,
// signed boundary products and asynchronous reset mid-operation.
module tb_mul_unit;
  localparam int unsigned STAGES = 4;
  localparam int unsigned CNT_W  = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             iss_mul_oper;
  logic [31:0]      iss_ex_rega, iss_ex_regb;
  logic [4:0]       iss_ex_regdest;
  logic             iss_ex_writereg;
  logic             wb_grant;
  logic             mul_wb_valid;
  logic [31:0]      mul_wb_lo, mul_wb_hi;
  logic [4:0]       mul_wb_regdest;
  logic             mul_wb_writereg;
  logic             mul_busy;
  logic [CNT_W-1:0] mul_inflight;
  logic             mul_overrun;

  int checks   = 0;
  int failures = 0;

  mul_unit #(.STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .iss_mul_oper   (iss_mul_oper),
    .iss_ex_rega    (iss_ex_rega),
    .iss_ex_regb    (iss_ex_regb),
    .iss_ex_regdest (iss_ex_regdest),
    .iss_ex_writereg(iss_ex_writereg),
    .wb_grant       (wb_grant),
    .mul_wb_valid   (mul_wb_valid),
    .mul_wb_lo      (mul_wb_lo),
    .mul_wb_hi      (mul_wb_hi),
    .mul_wb_regdest (mul_wb_regdest),
    .mul_wb_writereg(mul_wb_writereg),
    .mul_busy       (mul_busy),
    .mul_inflight   (mul_inflight),
    .mul_overrun    (mul_overrun)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic wr);
    iss_mul_oper    = op;
    iss_ex_rega     = a;
    iss_ex_regb     = b;
    iss_ex_regdest  = tag;
    iss_ex_writereg = wr;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    wb_grant = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0);
    tick();
    tick();
    checks++;
    if ({mul_wb_valid, mul_wb_lo, mul_wb_hi, mul_wb_regdest, mul_wb_writereg,
         mul_busy, mul_inflight, mul_overrun} !== '0) begin
      failures++;
      $display("FAIL reset_state got valid=%b hi=%h lo=%h inflight=%0d overrun=%b",
               mul_wb_valid, mul_wb_hi, mul_wb_lo, mul_inflight, mul_overrun);
    end
    #2 reset = 1'b1;
    tick();
    checks++;
    if (mul_wb_valid !== 1'b0 || mul_inflight !== '0) begin
      failures++;
      $display("FAIL post_release got valid=%b inflight=%0d exp 0/0", mul_wb_valid, mul_inflight);
    end
  endtask

  // 7 * -3 = -21, tag 5, grant held high
  task automatic test_single_op();
    wb_grant = 1'b1;
    drive(1'b1, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1);
    for (int c = 0; c < int'(STAGES); c++) begin
      tick();
      drive(1'b0, '0, '0, '0, 1'b0);
      if (c == 0) begin
        checks++;
        if (mul_inflight !== CNT_W'(1)) begin
          failures++;
          $display("FAIL single_inflight got=%0d exp=1", mul_inflight);
        end
      end
      checks++;
      if (mul_wb_valid !== (c == int'(STAGES) - 1)) begin
        failures++;
        $display("FAIL single_latency cycle=%0d got valid=%b exp=%b", c, mul_wb_valid,
                 (c == int'(STAGES) - 1));
      end
    end
    checks++;
    if ({mul_wb_hi, mul_wb_lo} !== 64'hFFFF_FFFF_FFFF_FFEB || mul_wb_regdest !== 5'd5 ||
        mul_wb_writereg !== 1'b1) begin
      failures++;
      $display("FAIL single_result got=%h_%h tag=%0d wr=%b exp=ffffffff_ffffffeb tag=5 wr=1",
               mul_wb_hi, mul_wb_lo, mul_wb_regdest, mul_wb_writereg);
    end
    tick();
    checks++;
    if (mul_wb_valid !== 1'b0 || mul_inflight !== '0) begin
      failures++;
      $display("FAIL single_drain got valid=%b inflight=%0d exp 0/0", mul_wb_valid, mul_inflight);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_lo [6] = '{32'd2, 32'd6, 32'd12, 32'd20, 32'd30, 32'd42};
    int n = 0;
    int first = -1;
    int last = -1;
    wb_grant = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c < 6) drive(1'b1, 32'(c + 1), 32'(c + 2), 5'(c + 1), 1'b1);
      else       drive(1'b0, '0, '0, '0, 1'b0);
      tick();
      checks++;
      if (mul_busy !== 1'b0) begin
        failures++;
        $display("FAIL b2b_busy cycle=%0d got=%b exp=0", c, mul_busy);
      end
      if (mul_wb_valid === 1'b1) begin
        if (first < 0) first = c;
        last = c;
        if (n < 6) begin
          checks++;
          if (mul_wb_lo !== exp_lo[n] || mul_wb_hi !== 32'd0) begin
            failures++;
            $display("FAIL b2b_value idx=%0d got=%h_%h exp=00000000_%h", n, mul_wb_hi, mul_wb_lo,
                     exp_lo[n]);
          end
        end
        n++;
      end
    end
    drive(1'b0, '0, '0, '0, 1'b0);
    checks++;
    if (n !== 6 || first !== int'(STAGES) - 1 || last - first !== 5) begin
      failures++;
      $display("FAIL b2b_stream got count=%0d first=%0d last=%0d exp 6/%0d/%0d", n, first, last,
               STAGES - 1, STAGES + 4);
    end
  endtask

  task automatic test_hold();
    int w = 0;
    wb_grant = 1'b0;
    drive(1'b1, 32'd3, 32'd5, 5'd7, 1'b1);
    tick();
    drive(1'b1, 32'hFFFF_FFFE, 32'd4, 5'd8, 1'b1);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0);
    while (mul_wb_valid !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    checks++;
    if (mul_wb_valid !== 1'b1) begin
      failures++;
      $display("FAIL hold_timeout got valid=%b exp=1", mul_wb_valid);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (mul_wb_valid !== 1'b1 || mul_wb_lo !== 32'd15 || mul_wb_hi !== 32'd0 ||
          mul_wb_regdest !== 5'd7 || mul_busy !== 1'b1 || mul_inflight !== CNT_W'(2)) begin
        failures++;
        $display("FAIL hold_frozen cycle=%0d got v=%b %h_%h tag=%0d busy=%b infl=%0d exp 1 0_f 7 1 2",
                 c, mul_wb_valid, mul_wb_hi, mul_wb_lo, mul_wb_regdest, mul_busy, mul_inflight);
      end
    end
    wb_grant = 1'b1;
    tick();
    checks++;
    if (mul_wb_valid !== 1'b1 || {mul_wb_hi, mul_wb_lo} !== 64'hFFFF_FFFF_FFFF_FFF8 ||
        mul_wb_regdest !== 5'd8 || mul_inflight !== CNT_W'(1)) begin
      failures++;
      $display("FAIL hold_second got v=%b %h_%h tag=%0d infl=%0d exp 1 ffffffff_fffffff8 8 1",
               mul_wb_valid, mul_wb_hi, mul_wb_lo, mul_wb_regdest, mul_inflight);
    end
    tick();
    checks++;
    if (mul_wb_valid !== 1'b0 || mul_inflight !== '0) begin
      failures++;
      $display("FAIL hold_drain got valid=%b inflight=%0d exp 0/0", mul_wb_valid, mul_inflight);
    end
  endtask

  task automatic test_overrun();
    int w = 0;
    checks++;
    if (mul_overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clear got=%b exp=0", mul_overrun);
    end
    wb_grant = 1'b0;
    drive(1'b1, 32'd10, 32'd10, 5'd1, 1'b1);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0);
    while (mul_wb_valid !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    drive(1'b1, 32'd99, 32'd99, 5'd2, 1'b1);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0);
    checks++;
    if (mul_overrun !== 1'b1 || mul_inflight !== CNT_W'(1) || mul_wb_lo !== 32'd100) begin
      failures++;
      $display("FAIL overrun_set got ovr=%b infl=%0d lo=%0d exp 1 1 100",
               mul_overrun, mul_inflight, mul_wb_lo);
    end
    wb_grant = 1'b1;
    tick();
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (mul_wb_valid !== 1'b0) begin
        failures++;
        $display("FAIL overrun_leak cycle=%0d got valid=%b lo=%0d exp valid=0", c, mul_wb_valid,
                 mul_wb_lo);
      end
      tick();
    end
    checks++;
    if (mul_overrun !== 1'b1 || mul_inflight !== '0) begin
      failures++;
      $display("FAIL overrun_sticky got ovr=%b infl=%0d exp 1 0", mul_overrun, mul_inflight);
    end
  endtask

  task automatic test_boundary();
    logic [31:0] a_v [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] b_v [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [63:0] e_v [3] = '{64'h4000_0000_0000_0000, 64'h1, 64'h0000_0000_8000_0000};
    int n = 0;
    wb_grant = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c < 3) drive(1'b1, a_v[c], b_v[c], 5'(10 + c), 1'b0);
      else       drive(1'b0, '0, '0, '0, 1'b0);
      tick();
      if (mul_wb_valid === 1'b1 && n < 3) begin
        checks++;
        if ({mul_wb_hi, mul_wb_lo} !== e_v[n] || mul_wb_writereg !== 1'b0 ||
            mul_wb_regdest !== 5'(10 + n)) begin
          failures++;
          $display("FAIL boundary idx=%0d got=%h_%h wr=%b tag=%0d exp=%h wr=0 tag=%0d", n,
                   mul_wb_hi, mul_wb_lo, mul_wb_writereg, mul_wb_regdest, e_v[n], 10 + n);
        end
        n++;
      end
    end
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL boundary_count got=%0d exp=3", n);
    end
  endtask

  task automatic test_async_reset();
    wb_grant = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 32'(c + 2), 32'd3, 5'(20 + c), 1'b1);
      tick();
    end
    drive(1'b0, '0, '0, '0, 1'b0);
    tick();
    checks++;
    if (mul_wb_valid !== 1'b1 || mul_inflight !== CNT_W'(3)) begin
      failures++;
      $display("FAIL areset_setup got valid=%b inflight=%0d exp 1 3", mul_wb_valid, mul_inflight);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({mul_wb_valid, mul_wb_lo, mul_wb_hi, mul_wb_regdest, mul_wb_writereg,
         mul_busy, mul_inflight, mul_overrun} !== '0) begin
      failures++;
      $display("FAIL areset_immediate got valid=%b %h_%h tag=%0d infl=%0d ovr=%b exp all 0",
               mul_wb_valid, mul_wb_hi, mul_wb_lo, mul_wb_regdest, mul_inflight, mul_overrun);
    end
    tick();
    #2 reset = 1'b1;
    wb_grant = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (mul_wb_valid !== 1'b0) begin
        failures++;
        $display("FAIL areset_stale cycle=%0d got valid=%b exp=0", c, mul_wb_valid);
      end
    end
    test_single_op();
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_back_to_back();
    test_hold();
    test_overrun();
    test_boundary();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
Pipelined multiply functional unit in the execution stage, directly downstream of the issue stage. Accepts one MULT operation per cycle when the issue stage raises its multiply-select strobe. Produces the signed 64-bit product of the two register operands after a fixed latency, with its destination tag. Presents the result to the write-back arbiter through a valid/grant handshake and stalls internally while the grant is withheld.

Parameters:
STAGES, 4, pipeline depth = cycles from acceptance to result valid; legal range 1..8
CNT_W, 4, width of the in-flight counter; must hold STAGES

Ports:
clock  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
iss_mul_oper  input  1  issue stage selects this unit this cycle
iss_ex_rega  input  32  operand A, two's complement
iss_ex_regb  input  32  operand B, two's complement
iss_ex_regdest  input  5  destination register tag
iss_ex_writereg  input  1  operation writes a register
wb_grant  input  1  write-back arbiter accepts the current result
mul_wb_valid  output  1  result available at pipeline head
mul_wb_lo  output  32  product bits [31:0]
mul_wb_hi  output  32  product bits [63:32]
mul_wb_regdest  output  5  destination tag of the head result
mul_wb_writereg  output  1  writereg flag of the head result
mul_busy  output  1  unit cannot accept an operation this cycle
mul_inflight  output  CNT_W  number of valid operations in the pipe, head included
mul_overrun  output  1  sticky: an operation was presented while busy

Behaviour:
- Reset (reset=0, asynchronous): every stage valid bit = 0; mul_wb_valid=0; mul_wb_lo, mul_wb_hi = 0; mul_wb_regdest=0; mul_wb_writereg=0; mul_inflight=0; mul_overrun=0. Reset mid-operation discards all in-flight results with no write-back.
- Pipeline: STAGES registers, each holding valid, tag, writereg and partial/final product. The split of the multiply across stages is an implementation choice. The head value must equal the full signed 64-bit product of A and B.
- hold = mul_wb_valid & ~wb_grant. When hold=1, every stage keeps its contents and no new operation enters.
- mul_busy = hold, combinational.
- Accept: iss_mul_oper=1 & mul_busy=0 at a rising edge. The operands enter stage 1 with valid=1.
  - If iss_mul_oper=0 while not holding, a bubble (valid=0) enters.
- Latency: an operation accepted at edge k raises mul_wb_valid after edge k+STAGES-1, i.e. a result is visible STAGES cycles after the acceptance edge, with no holds in between.
  - Throughput is one per cycle with no holds.
  - Back-to-back operations emerge on consecutive cycles in issue order.
- Handshake: the head result is consumed on a rising edge where mul_wb_valid=1 & wb_grant=1.
  - On consumption the pipe advances; a valid stage STAGES-1 becomes the new head in the same edge.
  - wb_grant while mul_wb_valid=0 has no effect.
  - The outputs are stable while mul_wb_valid=1 & wb_grant=0.
- Dropped operation: iss_mul_oper=1 while mul_busy=1. The operation is not accepted and mul_overrun is set to 1. mul_overrun stays 1 until reset.
- mul_inflight: +1 on acceptance, −1 on consumption, unchanged when both happen on the same edge. It never exceeds STAGES.
- writereg=0 operations traverse the pipe and handshake normally. They carry mul_wb_writereg=0; the arbiter decides whether to discard them.
- Arithmetic boundaries (signed): 0x80000000 × 0x80000000 = 0x40000000_00000000; 0xFFFFFFFF × 0xFFFFFFFF = 1; 0x80000000 × 0xFFFFFFFF = 0x00000000_80000000.
- No X on outputs after reset, including bubble cycles. Data outputs are don't-care but must be driven while mul_wb_valid=0.

Test Plan:
1. Reset then single op: A=7, B=−3, tag=5, wb_grant=1 held. Required: mul_wb_valid high exactly STAGES cycles after the accept edge, {hi,lo}=0xFFFFFFFF_FFFFFFEB, regdest=5, inflight returns to 0.
2. Stream of 6 back-to-back ops, operands i and i+1 (i=1..6), grant=1. Required: six consecutive valid cycles with lo=2,6,12,20,30,42 and busy never asserted.
3. Grant withheld 3 cycles while 2 ops are in flight. Required: head outputs frozen, mul_busy=1, mul_inflight constant. After grant returns, results drain in order with no loss or duplication.
4. iss_mul_oper=1 during a hold. Required: mul_overrun=1 stays set, the op never appears at the head, and mul_inflight is unchanged by it.
5. Boundary products (the three listed under Behaviour). Required: exact hi/lo values; writereg=0 propagates to mul_wb_writereg=0.
6. Assert reset with 3 ops in flight and the head valid. Required: all outputs zero immediately (asynchronously). After release, no stale result appears and a new op behaves as in scenario 1.
